// File: rtl/reg_bank16_if.sv
// Register-bank bus: single write port, clear request, status and the flat
// register image consumed by the read mux trees.
interface reg_bank16_if #(
    parameter int WIDTH = 64
);
    logic                   wr_en;
    logic [3:0]             wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic                   clr_req;
    logic                   busy;
    logic                   wr_drop;
    logic [16*WIDTH-1:0]    regs_flat;

    modport master (
        output wr_en, wr_addr, wr_data, clr_req,
        input  busy, wr_drop, regs_flat
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr_req,
        output busy, wr_drop, regs_flat
    );
endinterface

// File: rtl/reg_bank16.sv
// 16-entry register storage with one write port, a one-register-per-cycle
// clear engine and an optional hardwired-zero register 15. Every register
// is exposed flat so downstream read muxes can select from it.
module reg_bank16 #(
    parameter int WIDTH     = 64,
    parameter bit HARD_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    reg_bank16_if.slave  bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0] state_reg;
    logic [0:0] state_next;
    logic [3:0] ptr_reg;
    logic [3:0] ptr_next;
    logic       wr_drop_reg;
    logic       wr_drop_next;
    logic       wr_accept;

    // Next-state, clear pointer and write arbitration (clear wins over write)
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        wr_drop_next = 1'b0;
        wr_accept    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.clr_req) begin
                    state_next = CLEAR;
                    ptr_next   = 4'd0;
                end
                wr_drop_next = bus.wr_en && bus.clr_req;
                wr_accept    = bus.wr_en && !bus.clr_req;
            end
            CLEAR: begin
                // Further clear requests are ignored; the walk just continues.
                ptr_next     = 4'(ptr_reg + 4'd1);
                wr_drop_next = bus.wr_en;
                if (ptr_reg == 4'd15) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = 4'd0;
            end
        endcase
    end

    // Control state: FSM, clear pointer and the one-cycle drop pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= 4'd0;
            wr_drop_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            wr_drop_reg <= wr_drop_next;
        end
    end

    assign bus.busy    = (state_reg == CLEAR);
    assign bus.wr_drop = wr_drop_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg
            if (HARD_ZERO && gi == 15) begin : g_zero
                // Hardwired zero: writes to this index simply have no target.
                assign bus.regs_flat[gi*WIDTH +: WIDTH] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] data_reg;
                logic             clr_hit;
                logic             wr_hit;

                // wr_accept gates the address compare so X on an idle bus
                // cannot reach storage.
                assign clr_hit = (state_reg == CLEAR) && (ptr_reg == 4'(gi));
                assign wr_hit  = wr_accept && (bus.wr_addr == 4'(gi));

                // Per-register storage: clear engine or accepted write
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        data_reg <= '0;
                    end else if (clr_hit) begin
                        data_reg <= '0;
                    end else if (wr_hit) begin
                        data_reg <= bus.wr_data;
                    end
                end

                assign bus.regs_flat[gi*WIDTH +: WIDTH] = data_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_bank16.sv
// Scoreboard bench for reg_bank16: two instances (hardwired zero on and off)
// share one stimulus stream; a behavioural model pushes the expected state
// after each edge and a negedge monitor pops and compares.
module tb_reg_bank16;
    localparam int W = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_bank16_if #(.WIDTH(W)) bus1 ();
    reg_bank16_if #(.WIDTH(W)) bus0 ();

    reg_bank16 #(.WIDTH(W), .HARD_ZERO(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    reg_bank16 #(.WIDTH(W), .HARD_ZERO(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    typedef struct packed {
        logic [31:0]      cyc;
        logic [16*W-1:0]  flat1;
        logic [16*W-1:0]  flat0;
        logic             busy;
        logic             drop;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc_cnt = 0;
    int   txn = 0;

    // Reference model: plain register array, a separate reg 15 for the
    // non-hardwired instance, and a countdown of remaining clear cycles.
    logic [W-1:0] m [16];
    logic [W-1:0] m15_0;
    int           clr_left;
    int           clr_idx;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m[i] = '0;
        m15_0    = '0;
        clr_left = 0;
        clr_idx  = 0;
    endfunction

    task automatic set_inputs(input logic we, input logic [3:0] a, input logic [W-1:0] d, input logic clr);
        bus1.wr_en = we; bus1.wr_addr = a; bus1.wr_data = d; bus1.clr_req = clr;
        bus0.wr_en = we; bus0.wr_addr = a; bus0.wr_data = d; bus0.clr_req = clr;
    endtask

    // One transaction: present inputs for the next edge, step the model, queue expectation
    task automatic drive(input logic we, input logic [3:0] a, input logic [W-1:0] d, input logic clr);
        exp_t e;
        logic drop;
        @(posedge clk);
        #1;
        set_inputs(we, a, d, clr);
        drop = we && (clr_left > 0 || clr);
        if (clr_left > 0) begin
            if (clr_idx == 15) m15_0 = '0;
            else m[clr_idx] = '0;
            clr_idx++;
            clr_left--;
        end else if (clr) begin
            clr_left = 16;
            clr_idx  = 0;
        end else if (we) begin
            if (a == 4'd15) m15_0 = d;
            else m[a] = d;
        end
        for (int i = 0; i < 16; i++) begin
            e.flat1[i*W +: W] = (i == 15) ? '0 : m[i];
            e.flat0[i*W +: W] = (i == 15) ? m15_0 : m[i];
        end
        e.busy = (clr_left > 0);
        e.drop = drop;
        e.cyc  = 32'(cyc_cnt + 1);
        q.push_back(e);
        txn++;
        $display("txn %0d: we=%b addr=%h data=%h clr=%b", txn, we, a, d, clr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 4'bx, {W{1'bx}}, 1'b0);
    endtask

    task automatic check_reset_now();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rst_hz1_reg%0d", i), bus1.regs_flat[i*W +: W], '0);
            chk($sformatf("rst_hz0_reg%0d", i), bus0.regs_flat[i*W +: W], '0);
        end
        chk("rst_busy1", W'(bus1.busy), '0);
        chk("rst_drop1", W'(bus1.wr_drop), '0);
        chk("rst_busy0", W'(bus0.busy), '0);
        chk("rst_drop0", W'(bus0.wr_drop), '0);
    endtask

    // Mid-cycle asynchronous reset, checked before the next edge arrives
    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        set_inputs(1'b0, 4'd0, '0, 1'b0);
        #1;
        check_reset_now();
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare the queued expectation for the edge just taken
    always @(negedge clk) begin
        if (!reset) begin
            while (q.size() > 0 && int'(q[0].cyc) <= cyc_cnt) begin
                me = q.pop_front();
                if (int'(me.cyc) == cyc_cnt) begin
                    for (int i = 0; i < 16; i++) begin
                        chk($sformatf("hz1_reg%0d", i), bus1.regs_flat[i*W +: W], me.flat1[i*W +: W]);
                        chk($sformatf("hz0_reg%0d", i), bus0.regs_flat[i*W +: W], me.flat0[i*W +: W]);
                    end
                    chk("busy1", W'(bus1.busy), W'(me.busy));
                    chk("drop1", W'(bus1.wr_drop), W'(me.drop));
                    chk("busy0", W'(bus0.busy), W'(me.busy));
                    chk("drop0", W'(bus0.wr_drop), W'(me.drop));
                end
            end
        end
    end

    initial begin
        logic       we;
        logic       clr;
        logic [3:0] a;
        logic [W-1:0] d;

        reset = 1'b1;
        set_inputs(1'b0, 4'd0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Write/readback of 0..14, then address 15
        for (int i = 0; i < 15; i++) drive(1'b1, 4'(i), W'(64'h1111 * (i + 1)), 1'b0);
        drive(1'b1, 4'd15, W'(64'hDEAD), 1'b0);
        idle(2);

        // Asynchronous reset with populated registers
        async_reset();

        // Fill with all-ones pattern and run a full clear
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), W'(64'hFFFF), 1'b0);
        drive(1'b0, 4'd0, '0, 1'b1);
        idle(18);

        // Collisions: write with clear request, write during clear, re-request
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), W'(64'hFFFF), 1'b0);
        drive(1'b1, 4'd3, W'(64'hAAAA), 1'b1);
        idle(4);
        drive(1'b1, 4'd5, W'(64'h1234), 1'b0);
        idle(2);
        drive(1'b0, 4'd0, '0, 1'b1);
        idle(10);

        // Reset in the middle of a clear, then a normal write
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), {$urandom, $urandom}, 1'b0);
        drive(1'b0, 4'd0, '0, 1'b1);
        idle(7);
        async_reset();
        drive(1'b1, 4'd2, W'(64'h5A), 1'b0);
        idle(2);

        // Randomised traffic; address 15 kept out of clear windows
        for (int n = 0; n < 400; n++) begin
            clr = ($urandom_range(0, 24) == 0);
            we  = 1'($urandom_range(0, 1));
            a   = 4'($urandom_range(0, 15));
            d   = {$urandom, $urandom};
            if ((clr || clr_left > 0) && a == 4'd15) a = 4'd14;
            if (!we && $urandom_range(0, 3) == 0) drive(1'b0, 4'bx, {W{1'bx}}, clr);
            else drive(we, a, d, clr);
        end
        idle(2);

        repeat (3) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
